// File: rtl/led_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// led_pattern_gen_if
//   Groups the control inputs and LED outputs of the pattern engine into one
//   bundle.
//
//   Signals:
//     en          1 = prescaler and pattern advance; 0 = freeze both
//     mode        0 count, 1 bounce, 2 rotate, 3 all-on
//     brightness  global PWM duty (all-ones = constant on)
//     led         registered LED drive
//     step_tick   one-cycle pulse on each pattern step
//
//   Modports:
//     master  drives en/mode/brightness, observes led/step_tick
//     slave   the pattern engine itself
// ----------------------------------------------------------------------------
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 16,
    parameter int PWM_BITS = 8
);
    logic                en;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] brightness;
    logic [NUM_LEDS-1:0] led;
    logic                step_tick;

    modport master (output en, mode, brightness, input led, step_tick);
    modport slave  (input en, mode, brightness, output led, step_tick);
endinterface

// File: rtl/led_pattern_gen.sv
// ----------------------------------------------------------------------------
// led_pattern_gen
//   N-channel LED pattern engine: four animation modes (count, bounce,
//   rotate, all-on), a step prescaler of TICK_DIV clocks, and a global PWM
//   brightness applied to the registered LED outputs.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    led_pattern_gen_if.slave (en, mode, brightness, led, step_tick)
//
//   Optional build macro:
//     LED_GAMMA_EN  when defined, brightness is squared (>> PWM_BITS) through
//                   a registered perceptual curve before the PWM compare.
// ----------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int NUM_LEDS = 16,
    parameter int TICK_DIV = 1000000,
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_ALL_ON = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    mode_e               cur_mode,  cur_mode_nxt;
    dir_e                dir,       dir_nxt;
    logic [NUM_LEDS-1:0] pattern,   pattern_nxt;
    logic [PRE_W-1:0]    prescaler, prescaler_nxt;
    logic                step_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] eff;
    logic                full_on;
    logic                pwm_on;
    mode_e               req_mode;

    assign req_mode = mode_e'(bus.mode);

    // Pattern loaded when a new mode is taken. NUM_LEDS'(3) truncates to 1
    // for a single-LED bank, which is exactly the rotate seed wanted there.
    function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
        case (m)
            MODE_BOUNCE: return NUM_LEDS'(1);
            MODE_ROTATE: return NUM_LEDS'(3);
            MODE_ALL_ON: return '1;
            default:     return '0;
        endcase
    endfunction

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        cur_mode_nxt  = cur_mode;
        dir_nxt       = dir;
        pattern_nxt   = pattern;
        prescaler_nxt = prescaler;
        step_nxt      = 1'b0;

        if (req_mode != cur_mode) begin
            // Mode load wins over any step due in the same cycle.
            cur_mode_nxt  = req_mode;
            prescaler_nxt = '0;
            dir_nxt       = DIR_LEFT;
            pattern_nxt   = init_pattern(req_mode);
        end else if (bus.en) begin
            if (prescaler == PRE_LAST) begin
                prescaler_nxt = '0;
                step_nxt      = 1'b1;
                case (cur_mode)
                    MODE_COUNT: pattern_nxt = pattern + NUM_LEDS'(1);
                    MODE_BOUNCE: begin
                        if (NUM_LEDS == 1) begin
                            pattern_nxt = pattern;
                        end else if (dir == DIR_LEFT) begin
                            // Reaching the top end reverses immediately so
                            // the end bit is shown only once.
                            if (pattern[NUM_LEDS-1]) begin
                                dir_nxt     = DIR_RIGHT;
                                pattern_nxt = pattern >> 1;
                            end else begin
                                pattern_nxt = pattern << 1;
                            end
                        end else begin
                            if (pattern[0]) begin
                                dir_nxt     = DIR_LEFT;
                                pattern_nxt = pattern << 1;
                            end else begin
                                pattern_nxt = pattern >> 1;
                            end
                        end
                    end
                    // Shift-or form stays valid for NUM_LEDS = 1.
                    MODE_ROTATE: pattern_nxt = (pattern << 1) | (pattern >> (NUM_LEDS - 1));
                    default:     pattern_nxt = '1;
                endcase
            end else begin
                prescaler_nxt = prescaler + PRE_W'(1);
            end
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] bright_sq;
    assign bright_sq = {{PWM_BITS{1'b0}}, bus.brightness} * {{PWM_BITS{1'b0}}, bus.brightness};

    // Registered curve: brightness changes reach the compare one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff     <= '0;
            full_on <= 1'b0;
        end else begin
            eff     <= bright_sq[2*PWM_BITS-1:PWM_BITS];
            full_on <= (bus.brightness == '1);
        end
    end
`else
    assign eff     = bus.brightness;
    assign full_on = (bus.brightness == '1);
`endif

    assign pwm_on = full_on || (pwm_cnt < eff);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode      <= MODE_COUNT;
            dir           <= DIR_LEFT;
            pattern       <= '0;
            prescaler     <= '0;
            pwm_cnt       <= '0;
            bus.step_tick <= 1'b0;
            bus.led       <= '0;
        end else begin
            cur_mode      <= cur_mode_nxt;
            dir           <= dir_nxt;
            pattern       <= pattern_nxt;
            prescaler     <= prescaler_nxt;
            pwm_cnt       <= pwm_cnt + PWM_BITS'(1);
            bus.step_tick <= step_nxt;
            bus.led       <= pattern & {NUM_LEDS{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_gen
//   Directed bench for led_pattern_gen with NUM_LEDS=4, TICK_DIV=4,
//   PWM_BITS=2. Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int NUM_LEDS = 4;
    localparam int TICK_DIV = 4;
    localparam int PWM_BITS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    led_pattern_gen_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) bus ();

    led_pattern_gen #(
        .NUM_LEDS (NUM_LEDS),
        .TICK_DIV (TICK_DIV),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One prescaler period: led shows 'shown' throughout; step_tick is high
    // only after the fourth edge.
    task automatic step_group(input string tag, input logic [3:0] shown);
        for (int i = 0; i < TICK_DIV; i++) begin
            @(negedge clk);
            check({tag, " led"}, 32'(bus.led), 32'(shown));
            check({tag, " tick"}, 32'(bus.step_tick), (i == TICK_DIV - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Sample eight consecutive cycles of all-on output at the current
    // brightness and compare the number of lit cycles and step pulses.
    task automatic pwm_window(input string tag, input int exp_lit);
        int lit, bad, ticks;
        lit = 0; bad = 0; ticks = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.led == 4'b1111) lit++;
            else if (bus.led != 4'b0000) bad++;
            if (bus.step_tick) ticks++;
        end
        check({tag, " lit"}, 32'(lit), 32'(exp_lit));
        check({tag, " partial"}, 32'(bad), 32'd0);
        check({tag, " ticks"}, 32'(ticks), 32'd2);
    endtask

    logic [3:0] bseq [10];

    initial begin
        bseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        bus.en         = 1'b1;
        bus.mode       = 2'd0;
        bus.brightness = 2'b11;
        rst_n          = 1'b0;

        // 1. reset, then count through a full wrap
        repeat (3) begin
            @(negedge clk);
            check("reset led", 32'(bus.led), 32'd0);
            check("reset tick", 32'(bus.step_tick), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k <= 16; k++) step_group("count", 4'(k));

        // 2. bounce reversal (count pattern is now 0001)
        bus.mode = 2'd1;
        @(negedge clk);
        check("bounce load led", 32'(bus.led), 32'h1);
        check("bounce load tick", 32'(bus.step_tick), 32'd0);
        for (int i = 0; i < 10; i++) step_group("bounce", bseq[i]);

        // 3. count to 0101 then switch to rotate
        bus.mode = 2'd0;
        @(negedge clk);
        check("count load led", 32'(bus.led), 32'h4);
        for (int k = 0; k <= 4; k++) step_group("count2", 4'(k));
        bus.mode = 2'd2;
        @(negedge clk);
        check("rotate load led", 32'(bus.led), 32'h5);
        check("rotate load tick", 32'(bus.step_tick), 32'd0);
        step_group("rotate", 4'b0011);
        step_group("rotate", 4'b0110);
        step_group("rotate", 4'b1100);
        @(negedge clk);
        check("rotate wrap led", 32'(bus.led), 32'h9);

        // 4. freeze at 0011
        bus.mode = 2'd0;
        @(negedge clk);
        check("freeze load led", 32'(bus.led), 32'h9);
        for (int k = 0; k <= 2; k++) step_group("count3", 4'(k));
        bus.en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("freeze led", 32'(bus.led), 32'h3);
            check("freeze tick", 32'(bus.step_tick), 32'd0);
        end
        bus.en = 1'b1;
        step_group("thaw", 4'b0011);
        @(negedge clk);
        check("thaw led", 32'(bus.led), 32'h4);

        // 5. PWM in all-on mode
        bus.mode = 2'd3;
        @(negedge clk);
        check("allon load led", 32'(bus.led), 32'h4);
        @(negedge clk);
        check("allon full led", 32'(bus.led), 32'hF);
        bus.brightness = 2'd1;
`ifdef LED_GAMMA_EN
        pwm_window("pwm b1", 0);
`else
        pwm_window("pwm b1", 2);
`endif
        bus.brightness = 2'd0;
        pwm_window("pwm b0", 0);
        bus.brightness = 2'd3;
        pwm_window("pwm b3", 8);

        // 6. async reset mid-run in bounce mode
        bus.mode = 2'd1;
        @(negedge clk);
        step_group("bounce2", 4'b0001);
        step_group("bounce2", 4'b0010);
        #1;
        rst_n    = 1'b0;
        bus.mode = 2'd0;
        #1;
        check("async led", 32'(bus.led), 32'd0);
        check("async tick", 32'(bus.step_tick), 32'd0);
        @(negedge clk);
        check("async hold led", 32'(bus.led), 32'd0);
        rst_n = 1'b1;
        // cur_mode must be back to count: no load cycle before the first step
        step_group("post reset", 4'b0000);
        @(negedge clk);
        check("post reset led", 32'(bus.led), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine that drives the board LED bank from the free-running system clock. It generalises the fixed-width LED counter to N channels with four selectable animation modes, a programmable step prescaler and global PWM brightness. It sits directly under top, between the clock input and the led pins, and its outputs are fully registered.

Parameters:
NUM_LEDS, 16, number of LED channels (>=1)
TICK_DIV, 1000000, clk cycles per pattern step (>=2); 100 Hz step at 100 MHz
PWM_BITS, 8, width of the brightness value and of the PWM counter

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = prescaler and pattern advance; 0 = freeze both
mode  input  2  0 count, 1 bounce, 2 rotate, 3 all-on
brightness  input  PWM_BITS  global duty; all-ones = constant on
led  output  NUM_LEDS  registered LED drive
step_tick  output  1  one-cycle pulse on each pattern step

Behaviour:
- Reset, asynchronous on rst_n low: cur_mode=0, pattern=0, prescaler=0, pwm_cnt=0, dir=left, led=0, step_tick=0.
- Mode load: on any clock edge where mode != cur_mode, regardless of en:
  - cur_mode <= mode, prescaler <= 0, dir <= left, step_tick <= 0.
  - pattern <= init value: count 0; bounce 1; rotate 2'b11 zero-extended (1 if NUM_LEDS=1); all-on all ones.
  - Mode load takes priority over a step in the same cycle.
- Prescaler: runs only when en=1. Counts 0..TICK_DIV-1, then wraps to 0.
  - On the wrap edge, pattern advances one step and step_tick <= 1 on the same edge.
  - step_tick is 0 in every other cycle, including all cycles while en=0.
- Step rules:
  - count: pattern+1, modulo 2^NUM_LEDS; all-ones wraps to 0.
  - bounce: exactly one bit set. Shift toward dir; at bit NUM_LEDS-1 flip dir to right and shift right; at bit 0 with dir=right flip to left. End bits are shown once, not twice; e.g. N=4 gives 0001,0010,0100,1000,0100,0010,0001,0010. With NUM_LEDS=1, pattern stays at 1.
  - rotate: rotate left by 1 with MSB wrapping into bit 0.
  - all-on: pattern holds all ones and step_tick still pulses.
- en=0: prescaler, pattern and dir hold their values. The PWM counter keeps running and led keeps showing the frozen pattern.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps all-ones to 0 and ignores en.
  - pwm_on = (brightness == all-ones) || (pwm_cnt < brightness).
  - brightness 0 gives led constantly 0.
- Output: led <= pattern & {NUM_LEDS{pwm_on}} each clock. This adds one cycle of latency from a pattern update (and its step_tick) to led.
- brightness is sampled every cycle with no synchroniser; callers drive it from the clk domain.
- Reset asserted mid-step clears everything immediately. After release, the first step occurs TICK_DIV cycles after the first clock edge with en=1.

Optional Feature:
Macro: LED_GAMMA_EN.
- Defined: brightness passes through a perceptual curve before the compare.
  - eff = (brightness*brightness) >> PWM_BITS, computed at full 2*PWM_BITS width.
  - brightness all-ones still forces constant on; brightness 0 still gives off.
  - The mapping is registered, which adds one cycle of latency on brightness changes only.
- Undefined: eff = brightness directly, with no extra register.

Test Plan:
All scenarios use NUM_LEDS=4, TICK_DIV=4, PWM_BITS=2, brightness=3 unless stated.
1. Reset/count: hold rst_n=0 for 3 cycles, release with en=1, mode=0 -> led=0000 during reset; step_tick every 4th cycle; led goes 0001, 0010, … 1111, 0000, each 1 cycle after its step_tick.
2. Bounce reversal: mode=1 for 10 steps -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010,0100,1000 (init value then 9 steps).
3. Mode change mid-count: in mode 0 at pattern 0101, switch to mode=2 -> next edge pattern=0011, prescaler restarts, first step 4 cycles later gives 0110, then 1100, 1001.
4. Freeze: en=0 for 20 cycles in mode 0 at 0011 -> no step_tick, led stays 0011; en=1 -> 0100 after exactly 4 cycles.
5. PWM: mode=3, brightness=1 -> led=1111 for 1 of every 4 cycles; brightness=0 -> always 0000; brightness=3 -> always 1111.
6. Async reset mid-run: drop rst_n between clock edges in mode 1 -> led=0000 and step_tick=0 immediately, without waiting for a clock edge; cur_mode returns to 0.
